// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rstseq_pkg.sv
// Shared types and helpers for the reset release sequencer.
//   state_e      : sequencer FSM states (3-bit encoding)
//   cnt_width()  : bits needed to hold values 0..max_val (minimum 1)
package gf180mcu_fd_sc_mcu7t5v0__rstseq_pkg;

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_DONE       = 3'd3,
    ST_SOFT       = 3'd4
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rstsync.sv
// Reset synchroniser: asynchronous assertion, release synchronised to CLK.
//   CLK : clock
//   RN  : asynchronous active-low reset input
//   Q   : synchronised release (high STAGES edges after RN rises)
module gf180mcu_fd_sc_mcu7t5v0__rstsync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RN,
  output logic Q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign Q = sync_q[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rstseq.sv
// Reset release sequencer for the per-domain asynchronous reset nets.
// Assertion is asynchronous; release is synchronised and staggered by
// GAP_CYCLES across NUM_OUT outputs, bit 0 first. Also serves a 4-phase
// soft-reset handshake once the sequence has completed.
//   CLK      : clock
//   RN       : asynchronous active-low chip reset
//   READY    : release may start only while high
//   SRST_REQ : soft-reset request (level, 4-phase)
//   SRST_ACK : soft-reset acknowledge
//   RSTN_OUT : active-low domain resets (registered)
//   DONE     : all RSTN_OUT released (registered)
module gf180mcu_fd_sc_mcu7t5v0__rstseq
  import gf180mcu_fd_sc_mcu7t5v0__rstseq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic               CLK,
  input  logic               RN,
  input  logic               READY,
  input  logic               SRST_REQ,
  output logic               SRST_ACK,
  output logic [NUM_OUT-1:0] RSTN_OUT,
  output logic               DONE
);

  localparam int unsigned CNT_W = cnt_width(GAP_CYCLES);
  localparam int unsigned IDX_W = cnt_width(NUM_OUT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_OUT - 1);

  logic rn_sync;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] rstn_out_q, rstn_out_d;
  logic               done_q, done_d;
  logic               srst_ack_q, srst_ack_d;

  gf180mcu_fd_sc_mcu7t5v0__rstsync #(
    .STAGES (SYNC_STAGES)
  ) u_rstsync (
    .CLK (CLK),
    .RN  (RN),
    .Q   (rn_sync)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rstn_out_d = rstn_out_q;
    done_d     = done_q;
    srst_ack_d = srst_ack_q;
    case (state_q)
      ST_RESET: begin
        if (rn_sync) state_d = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (READY) begin
          rstn_out_d[0] = 1'b1;
          cnt_d         = CNT_RELOAD;
          idx_d         = IDX_W'(1);
          // A single output completes the sequence on its first release.
          if (NUM_OUT == 1) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (cnt_q == '0) begin
          // Decoded set keeps the index width independent of NUM_OUT's range.
          for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (idx_q == IDX_W'(i)) rstn_out_d[i] = 1'b1;
          end
          cnt_d = CNT_RELOAD;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (SRST_REQ) begin
          rstn_out_d = '0;
          done_d     = 1'b0;
          srst_ack_d = 1'b1;
          state_d    = ST_SOFT;
        end
      end
      ST_SOFT: begin
        if (!SRST_REQ) begin
          srst_ack_d = 1'b0;
          state_d    = ST_WAIT_READY;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      idx_q      <= '0;
      rstn_out_q <= '0;
      done_q     <= 1'b0;
      srst_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rstn_out_q <= rstn_out_d;
      done_q     <= done_d;
      srst_ack_q <= srst_ack_d;
    end
  end

  assign RSTN_OUT = rstn_out_q;
  assign DONE     = done_q;
  assign SRST_ACK = srst_ack_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rstseq.sv
// Self-checking bench for the reset release sequencer. Two instances share
// all inputs: the default configuration and NUM_OUT=1/GAP=1/SYNC=3.
module tb_gf180mcu_fd_sc_mcu7t5v0__rstseq;

  localparam int P_SYNC = 0;
  localparam int P_WAIT = 1;
  localparam int P_SEQ  = 2;
  localparam int P_SOFT = 3;

  logic clk = 1'b0;
  logic rn;
  logic ready;
  logic req;

  logic [3:0] rstn0;
  logic       done0, ack0;
  logic [0:0] rstn1;
  logic       done1, ack1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__rstseq #(
    .SYNC_STAGES (2),
    .NUM_OUT     (4),
    .GAP_CYCLES  (4)
  ) dut0 (
    .CLK      (clk),
    .RN       (rn),
    .READY    (ready),
    .SRST_REQ (req),
    .SRST_ACK (ack0),
    .RSTN_OUT (rstn0),
    .DONE     (done0)
  );

  gf180mcu_fd_sc_mcu7t5v0__rstseq #(
    .SYNC_STAGES (3),
    .NUM_OUT     (1),
    .GAP_CYCLES  (1)
  ) dut1 (
    .CLK      (clk),
    .RN       (rn),
    .READY    (ready),
    .SRST_REQ (req),
    .SRST_ACK (ack1),
    .RSTN_OUT (rstn1),
    .DONE     (done1)
  );

  // Reference model: tracks edges since RN release and edges spent in the
  // release sequence; released-output count = min(N, seq_edges/G + 1).
  for (genvar k = 0; k < 2; k++) begin : g_model
    localparam int MS = (k == 0) ? 2 : 3;
    localparam int MN = (k == 0) ? 4 : 1;
    localparam int MG = (k == 0) ? 4 : 1;

    int phase     = P_SYNC;
    int rn_edges  = 0;
    int seq_edges = 0;
    int rel_cnt;
    logic [3:0] exp_rstn;
    logic       exp_done;
    logic       exp_ack;

    always_comb begin
      rel_cnt = 0;
      if (phase == P_SEQ) begin
        rel_cnt = seq_edges / MG + 1;
        if (rel_cnt > MN) rel_cnt = MN;
      end
      exp_rstn = '0;
      for (int i = 0; i < 4; i++) begin
        if (i < rel_cnt) exp_rstn[i] = 1'b1;
      end
      exp_done = (phase == P_SEQ) && (rel_cnt == MN);
      exp_ack  = (phase == P_SOFT);
    end

    always @(posedge clk or negedge rn) begin
      if (!rn) begin
        phase     <= P_SYNC;
        rn_edges  <= 0;
        seq_edges <= 0;
      end else begin
        rn_edges <= rn_edges + 1;
        case (phase)
          P_SYNC: if (rn_edges == MS) phase <= P_WAIT;
          P_WAIT: if (ready) begin
                    phase     <= P_SEQ;
                    seq_edges <= 0;
                  end
          P_SEQ:  if (rel_cnt == MN && req) phase <= P_SOFT;
                  else seq_edges <= seq_edges + 1;
          default: if (!req) phase <= P_WAIT;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input string sig,
                     input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, sig, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "rstn0", rstn0, g_model[0].exp_rstn);
    chk(tag, "done0", {3'b0, done0}, {3'b0, g_model[0].exp_done});
    chk(tag, "ack0",  {3'b0, ack0},  {3'b0, g_model[0].exp_ack});
    chk(tag, "rstn1", {3'b0, rstn1}, g_model[1].exp_rstn);
    chk(tag, "done1", {3'b0, done1}, {3'b0, g_model[1].exp_done});
    chk(tag, "ack1",  {3'b0, ack1},  {3'b0, g_model[1].exp_ack});
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  // RN pulsed low mid-cycle; outputs must clear without a clock edge.
  task automatic rn_pulse(input string tag);
    #2 rn = 1'b0;
    #1;
    check_all(tag);
    chk(tag, "async_rstn0", rstn0, 4'b0000);
    chk(tag, "async_done0", {3'b0, done0}, 4'b0000);
    @(negedge clk);
    rn = 1'b1;
  endtask

  initial begin
    rn    = 1'b0;
    ready = 1'b1;
    req   = 1'b0;
    repeat (3) step("reset");
    chk("reset", "rstn0_const", rstn0, 4'b0000);

    // Power-on release with READY held high.
    rn = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      step("boot");
      if (e == 4)  chk("boot_e4",  "rstn0", rstn0, 4'b0001);
      if (e == 8)  chk("boot_e8",  "rstn0", rstn0, 4'b0011);
      if (e == 12) chk("boot_e12", "rstn0", rstn0, 4'b0111);
      if (e == 15) chk("boot_e15", "done0", {3'b0, done0}, 4'b0000);
      if (e == 16) begin
        chk("boot_e16", "rstn0", rstn0, 4'b1111);
        chk("boot_e16", "done0", {3'b0, done0}, 4'b0001);
      end
      if (e == 4) chk("n1_e4", "rstn1", {3'b0, rstn1}, 4'b0000);
      if (e == 5) begin
        chk("n1_e5", "rstn1", {3'b0, rstn1}, 4'b0001);
        chk("n1_e5", "done1", {3'b0, done1}, 4'b0001);
      end
    end

    // Soft reset handshake, request held 5 cycles.
    req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step("soft_req");
      chk("soft_req", "ack0", {3'b0, ack0}, 4'b0001);
      chk("soft_req", "rstn0", rstn0, 4'b0000);
    end
    req = 1'b0;
    step("soft_drop");
    chk("soft_drop", "ack0", {3'b0, ack0}, 4'b0000);
    for (int e = 1; e <= 13; e++) begin
      step("soft_rel");
      if (e == 1)  chk("soft_rel_m1", "rstn0", rstn0, 4'b0001);
      if (e == 12) chk("soft_rel_m12", "done0", {3'b0, done0}, 4'b0000);
      if (e == 13) begin
        chk("soft_rel_m13", "rstn0", rstn0, 4'b1111);
        chk("soft_rel_m13", "done0", {3'b0, done0}, 4'b0001);
      end
    end

    // READY late: held low for 10 cycles after the FSM reaches WAIT_READY.
    ready = 1'b0;
    rn_pulse("late_rn");
    for (int e = 1; e <= 13; e++) begin
      step("late_wait");
      chk("late_wait", "rstn0", rstn0, 4'b0000);
    end
    ready = 1'b1;
    step("late_go");
    chk("late_go", "rstn0", rstn0, 4'b0001);
    for (int e = 1; e <= 12; e++) begin
      step("late_rel");
      if (e == 11) chk("late_e11", "done0", {3'b0, done0}, 4'b0000);
      if (e == 12) chk("late_e12", "done0", {3'b0, done0}, 4'b0001);
    end

    // RN pulse mid-release, then a full restart.
    rn_pulse("mid_rn0");
    for (int e = 1; e <= 8; e++) step("mid_pre");
    chk("mid_pre_e8", "rstn0", rstn0, 4'b0011);
    rn_pulse("mid_rn");
    for (int e = 1; e <= 16; e++) begin
      step("mid_restart");
      if (e == 4)  chk("mid_e4",  "rstn0", rstn0, 4'b0001);
      if (e == 16) chk("mid_e16", "rstn0", rstn0, 4'b1111);
    end

    // SRST_REQ raised during RELEASE stays pending until DONE.
    rn_pulse("pend_rn");
    for (int e = 1; e <= 4; e++) step("pend_pre");
    req = 1'b1;
    for (int e = 5; e <= 17; e++) begin
      step("pend");
      if (e == 15) begin
        chk("pend_e15", "rstn0", rstn0, 4'b0111);
        chk("pend_e15", "ack0", {3'b0, ack0}, 4'b0000);
      end
      if (e == 16) begin
        chk("pend_e16", "rstn0", rstn0, 4'b1111);
        chk("pend_e16", "ack0", {3'b0, ack0}, 4'b0000);
      end
      if (e == 17) begin
        chk("pend_e17", "rstn0", rstn0, 4'b0000);
        chk("pend_e17", "ack0", {3'b0, ack0}, 4'b0001);
      end
    end
    req = 1'b0;
    repeat (15) step("pend_post");

    // Randomised READY / SRST_REQ / RN activity against the model.
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 99) < 2) rn_pulse("rand_rn");
      if ($urandom_range(0, 99) < 15) ready = ~ready;
      if ($urandom_range(0, 99) < 8)  req = ~req;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__rstseq.md
# gf180mcu_fd_sc_mcu7t5v0__rstseq

Reset release sequencer driving the asynchronous SETN/RN pins of the library's set/reset flip-flops. Reset assertion is asynchronous. Release is synchronised to CLK and staggered across NUM_OUT domains, so every downstream flop sees release on a clock edge and meets its recovery and removal checks. Sits between the chip-level reset pad and the per-domain reset nets; also provides a 4-phase soft-reset handshake.

## Interface
- SYNC_STAGES, 2: synchroniser depth on RN release; legal range ≥2.
- NUM_OUT, 4: number of sequenced reset outputs; legal range ≥1.
- GAP_CYCLES, 4: CLK cycles between successive output releases; legal range ≥1.
- CLK  in  1  clock; all state changes on rising edge except reset assertion.
- RN  in  1  reset; asynchronous, active-low.
- READY  in  1  synchronous to CLK; release may start only while high (e.g. PLL lock).
- SRST_REQ  in  1  soft-reset request, level, 4-phase.
- SRST_ACK  out  1  soft-reset acknowledge.
- RSTN_OUT  out  NUM_OUT  active-low domain resets; bit 0 released first.
- DONE  out  1  high once all RSTN_OUT are released.

## Operation
- RN low: asynchronously RSTN_OUT=0, DONE=0, SRST_ACK=0, synchroniser cleared, FSM=RESET, gap counter=0, index=0. All registers reset to 0.
- Synchroniser: SYNC_STAGES-deep chain, async-cleared by RN, shifts in 1; output rn_sync.
- FSM states: RESET, WAIT_READY, RELEASE, DONE, SOFT.
- RESET→WAIT_READY when rn_sync=1.
- WAIT_READY→RELEASE when READY=1; on that edge RSTN_OUT[0]←1, counter←GAP_CYCLES−1, index←1.
- RELEASE: counter decrements each edge. At counter==0, RSTN_OUT[index]←1, counter reloads, index increments.
- DONE is set on the same edge as RSTN_OUT[NUM_OUT−1]; the FSM then enters DONE.
- NUM_OUT=1: FSM goes WAIT_READY→DONE directly; RSTN_OUT[0] and DONE rise together.
- READY falling during RELEASE or DONE: ignored; the sequence is never paused.
- Soft reset, entered from DONE with SRST_REQ=1:
  - next edge: RSTN_OUT←all 0, DONE←0, SRST_ACK←1, FSM=SOFT (synchronous assertion).
  - SOFT holds while SRST_REQ=1.
  - SRST_REQ=0: next edge SRST_ACK←0, FSM→WAIT_READY; the full release sequence repeats.
- SRST_REQ=1 outside DONE: no effect; the request stays pending and is taken on the first DONE cycle.
- Released RSTN_OUT bits never return to 0 except via RN or soft reset.
- Counter width is $clog2(GAP_CYCLES+1). Index width is $clog2(NUM_OUT+1).

## Timing
- Edges are counted after RN rises with READY=1 held. S=SYNC_STAGES, G=GAP_CYCLES.
  - rn_sync=1 after edge S.
  - FSM=WAIT_READY after edge S+1.
  - RSTN_OUT[i] rises at edge S+2+i·G.
  - DONE rises at edge S+2+(NUM_OUT−1)·G.
- READY late: RSTN_OUT[0] rises on the first edge that samples READY=1 in WAIT_READY.
- Soft reset:
  - SRST_REQ sampled high in DONE at edge k: outputs fall and SRST_ACK rises at edge k.
  - SRST_REQ sampled low at edge m: SRST_ACK falls at m; RSTN_OUT[0] rises at m+1 if READY=1.
- RN assertion mid-sequence or mid-handshake: immediate asynchronous return to the reset values above. No glitch on RSTN_OUT.
- All outputs are direct flop Q outputs. No combinational path from inputs to outputs.

## Structure
- Package gf180mcu_fd_sc_mcu7t5v0__rstseq_pkg holds:
  - the state enum (RESET, WAIT_READY, RELEASE, DONE, SOFT, 3-bit encoding);
  - a width helper function for counter and index.
- Sub-module gf180mcu_fd_sc_mcu7t5v0__rstsync: the SYNC_STAGES chain. Ports CLK, RN, Q.
- Top level holds the FSM, gap counter, index and output registers.

## Test plan
- Defaults, RN released, READY=1: RSTN_OUT goes 0001@edge4, 0011@8, 0111@12, 1111@16; DONE=1@16.
- READY held 0 for 10 cycles after rn_sync: RSTN_OUT stays 0000. READY→1 sampled at edge e gives RSTN_OUT[0]=1@e, DONE@e+12.
- RN pulsed low mid-release (after RSTN_OUT=0011): RSTN_OUT=0000 and DONE=0 immediately, without waiting for CLK; the full sequence restarts from edge 1.
- Soft reset at DONE, SRST_REQ high 5 cycles:
  - RSTN_OUT=0000 and SRST_ACK=1 one edge after the request; ACK holds for the whole request.
  - ACK drops one edge after SRST_REQ falls; re-release completes 13 edges later (1 + 3·4).
- SRST_REQ raised during RELEASE: no output change until DONE; the handshake is then taken on the first DONE cycle.
- NUM_OUT=1, GAP_CYCLES=1, SYNC_STAGES=3: RSTN_OUT[0] and DONE both rise at edge 5.
